// File: rtl/vga_sync_gen_pkg.sv
// vga_pkg: shared types and constants for the VGA timing generator.
//   axis_state_t : per-axis porch/sync phase (ACTIVE, FRONT, SYNC, BACK)
//   COUNT_W      : width of the axis position counters
//   *_DEF        : default 640x480 @ 60 Hz timing, 125 MHz clk / 5 = 25 MHz pixel
package vga_pkg;

    localparam int COUNT_W = 12;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } axis_state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam bit H_POL_DEF    = 1'b0;
    localparam bit V_POL_DEF    = 1'b0;
    localparam int CLK_DIV_DEF  = 5;

    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_gen_sync_axis.sv
// sync_axis: one axis (horizontal or vertical) of the VGA timing generator.
// Position counter plus the ACTIVE -> FRONT -> SYNC -> BACK phase machine.
//
// State table:
//   ACTIVE | visible region, count 0 .. ACTIVE_LEN-1
//   FRONT  | front porch
//   SYNC   | sync pulse, sync output at POL level
//   BACK   | back porch, ends at TOTAL-1 and wraps to 0
//
// Ports:
//   clk, reset (sync, active-high), step (advance one position)
//   count     : current position 0..TOTAL-1
//   state     : current phase
//   wrap      : count is at TOTAL-1 (next step returns to 0)
//   sync      : registered sync level
//   in_active : registered, high while in ACTIVE
module sync_axis
    import vga_pkg::*;
#(
    parameter int ACTIVE_LEN = H_ACTIVE_DEF,
    parameter int FP_LEN     = H_FP_DEF,
    parameter int SYNC_LEN   = H_SYNC_DEF,
    parameter int BP_LEN     = H_BP_DEF,
    parameter bit POL        = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    output logic [COUNT_W-1:0] count,
    output axis_state_t        state,
    output logic               wrap,
    output logic               sync,
    output logic               in_active
);

    localparam int TOTAL = axis_total(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);

    // Last position of each phase.
    localparam logic [COUNT_W-1:0] ACT_END  = COUNT_W'(ACTIVE_LEN - 1);
    localparam logic [COUNT_W-1:0] FP_END   = COUNT_W'(ACTIVE_LEN + FP_LEN - 1);
    localparam logic [COUNT_W-1:0] SYNC_END = COUNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
    localparam logic [COUNT_W-1:0] LAST     = COUNT_W'(TOTAL - 1);

    logic [COUNT_W-1:0] count_q, count_d;
    axis_state_t        state_q;
    logic               sync_q;
    logic               active_q;

    assign wrap    = (count_q == LAST);
    assign count_d = wrap ? '0 : count_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            state_q  <= ACTIVE;
            sync_q   <= ~POL;
            active_q <= 1'b1;
        end else if (step) begin
            count_q <= count_d;
            unique case (state_q)
                ACTIVE: if (count_q == ACT_END) begin
                    state_q  <= FRONT;
                    active_q <= 1'b0;
                end
                FRONT: if (count_q == FP_END) begin
                    state_q <= SYNC;
                    sync_q  <= POL;
                end
                SYNC: if (count_q == SYNC_END) begin
                    state_q <= BACK;
                    sync_q  <= ~POL;
                end
                BACK: if (wrap) begin
                    state_q  <= ACTIVE;
                    active_q <= 1'b1;
                end
                default: begin
                    state_q  <= ACTIVE;
                    sync_q   <= ~POL;
                    active_q <= 1'b1;
                end
            endcase
        end
    end

    assign count     = count_q;
    assign state     = state_q;
    assign sync      = sync_q;
    assign in_active = active_q;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parametrised VGA timing generator.
// Clock prescaler, running flag, horizontal/vertical sync_axis instances and
// line/frame start pulses. All outputs come from registers.
//
// Ports:
//   clk, reset (sync, active-high), enable (low freezes everything)
//   pix_tick              : one-clk strobe per pixel period
//   hcount, vcount        : pixel position
//   hsync, vsync          : sync at H_POL / V_POL active level
//   video_on              : both axes visible and generator running
//   line_start/frame_start: one-clk pulses after the tick that lands on hcount 0
//   x_pos, y_pos          : only with VGA_SYNC_COORD_EN defined; hcount/vcount
//                           while video_on, else 0
//
// Optional feature macro: VGA_SYNC_COORD_EN
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit H_POL    = H_POL_DEF,
    parameter bit V_POL    = V_POL_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               pix_tick,
    output logic [COUNT_W-1:0] hcount,
    output logic [COUNT_W-1:0] vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               line_start,
    output logic               frame_start
`ifdef VGA_SYNC_COORD_EN
    ,
    output logic [COUNT_W-1:0] x_pos,
    output logic [COUNT_W-1:0] y_pos
`endif
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    if (H_TOTAL > 4095 || V_TOTAL > 4095 ||
        H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        CLK_DIV < 1 || CLK_DIV > 15) begin : g_bad_cfg
        $error("vga_sync_gen: illegal timing parameters");
    end

    // enable is registered so nothing downstream sees it combinationally;
    // a freeze therefore lasts exactly as many clks as enable was low.
    logic        en_q;
    logic [3:0]  div_q, div_d;
    logic        running_q;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        h_step, v_step, h_wrap, v_wrap, h_end, v_end;
    logic        h_in_active, v_in_active;
    axis_state_t h_state, v_state;

    assign pix_tick = en_q && (div_q == DIV_LAST);
    assign div_d    = pix_tick ? '0 : div_q + 1'b1;

    // The tick that sets running leaves the counters at 0.
    assign h_step = pix_tick && running_q;
    assign v_step = h_step && h_wrap;

    assign h_end = h_wrap && (h_state == BACK);
    assign v_end = v_wrap && (v_state == BACK);

    assign line_start_d  = pix_tick && (!running_q || h_end);
    assign frame_start_d = pix_tick && (!running_q || (h_end && v_end));

    sync_axis #(
        .ACTIVE_LEN (H_ACTIVE),
        .FP_LEN     (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BP_LEN     (H_BP),
        .POL        (H_POL)
    ) u_h_axis (
        .clk       (clk),
        .reset     (reset),
        .step      (h_step),
        .count     (hcount),
        .state     (h_state),
        .wrap      (h_wrap),
        .sync      (hsync),
        .in_active (h_in_active)
    );

    sync_axis #(
        .ACTIVE_LEN (V_ACTIVE),
        .FP_LEN     (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BP_LEN     (V_BP),
        .POL        (V_POL)
    ) u_v_axis (
        .clk       (clk),
        .reset     (reset),
        .step      (v_step),
        .count     (vcount),
        .state     (v_state),
        .wrap      (v_wrap),
        .sync      (vsync),
        .in_active (v_in_active)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q          <= 1'b0;
            div_q         <= '0;
            running_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            en_q          <= enable;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            if (en_q) begin
                div_q <= div_d;
            end
            if (pix_tick) begin
                running_q <= 1'b1;
            end
        end
    end

    assign video_on    = running_q && h_in_active && v_in_active;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_SYNC_COORD_EN
    // Coordinates are registered from the post-tick position so they change
    // on the same edge as video_on.
    localparam logic [COUNT_W-1:0] H_ACT_W = COUNT_W'(H_ACTIVE);
    localparam logic [COUNT_W-1:0] V_ACT_W = COUNT_W'(V_ACTIVE);

    logic [COUNT_W-1:0] h_next, v_next;
    logic [COUNT_W-1:0] x_pos_q, y_pos_q;
    logic               vid_next;

    assign h_next   = h_step ? (h_wrap ? '0 : hcount + 1'b1) : hcount;
    assign v_next   = v_step ? (v_wrap ? '0 : vcount + 1'b1) : vcount;
    assign vid_next = (running_q || pix_tick) && (h_next < H_ACT_W) && (v_next < V_ACT_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            x_pos_q <= '0;
            y_pos_q <= '0;
        end else if (pix_tick) begin
            x_pos_q <= vid_next ? h_next : '0;
            y_pos_q <= vid_next ? v_next : '0;
        end
    end

    assign x_pos = x_pos_q;
    assign y_pos = y_pos_q;
`endif

endmodule
